// File: rtl/pu_msp430_per_mailbox_if.sv
// Peripheral-bus and TX/RX stream signals of the mailbox peripheral.
interface pu_msp430_per_mailbox_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic        irq;

  modport slave (
    input  per_addr, per_din, per_en, per_we, tx_ready, rx_valid, rx_data,
    output per_dout, tx_valid, tx_data, rx_ready, irq
  );

  modport master (
    output per_addr, per_din, per_en, per_we, tx_ready, rx_valid, rx_data,
    input  per_dout, tx_valid, tx_data, rx_ready, irq
  );
endinterface

// File: rtl/pu_msp430_per_mailbox.sv
// Memory-mapped word mailbox: CPU-fed TX FIFO, source-fed RX FIFO,
// STATUS/CTRL registers and a level interrupt on the MSP430 peripheral bus.
module pu_msp430_per_mailbox #(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter int unsigned DEPTH     = 4
) (
  input logic                     mclk,
  input logic                     puc_rst_n,
  pu_msp430_per_mailbox_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          txie, rxie, txovf, rxunf;

  logic          sel, rd, wr;
  logic [1:0]    off;
  logic [15:0]   tx_word, status;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_pop, tx_push, tx_flush, ovf_set, ovf_clr;
  logic          rx_pop, rx_push, rx_flush, unf_set, unf_clr;
  logic          ctrl_wr;

  // Address decode, FIFO handshakes and register side effects
  always_comb begin
    sel      = bus.per_en && (bus.per_addr[13:2] == BASE_ADDR[14:3]);
    off      = bus.per_addr[1:0];
    rd       = sel && (bus.per_we == 2'b00);
    wr       = sel && (bus.per_we != 2'b00);
    tx_word  = {bus.per_we[1] ? bus.per_din[15:8] : 8'h00,
                bus.per_we[0] ? bus.per_din[7:0]  : 8'h00};
    tx_full  = (tx_cnt == FULL_CNT);
    tx_empty = (tx_cnt == '0);
    rx_full  = (rx_cnt == FULL_CNT);
    rx_empty = (rx_cnt == '0);
    ctrl_wr  = wr && (off == 2'd3);
    tx_flush = ctrl_wr && bus.per_din[2];
    rx_flush = ctrl_wr && bus.per_din[3];
    tx_pop   = !tx_empty && bus.tx_ready;
    // A push into a full TX FIFO only fits when the sink frees the head slot
    tx_push  = wr && (off == 2'd0) && (!tx_full || tx_pop);
    ovf_set  = wr && (off == 2'd0) && tx_full && !tx_pop && !tx_flush;
    ovf_clr  = wr && (off == 2'd2) && bus.per_din[4];
    rx_pop   = rd && (off == 2'd1) && !rx_empty;
    unf_set  = rd && (off == 2'd1) && rx_empty;
    unf_clr  = wr && (off == 2'd2) && bus.per_din[5];
    rx_push  = bus.rx_valid && !rx_full;
    status   = {4'(rx_cnt), 4'(tx_cnt), 2'b00, rxunf, txovf,
                rx_empty, rx_full, tx_empty, tx_full};
  end

  // Read mux; the backbone registers per_dout, so it is combinational here
  always_comb begin
    bus.per_dout = 16'h0000;
    if (rd) begin
      case (off)
        2'd1:    bus.per_dout = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
        2'd2:    bus.per_dout = status;
        2'd3:    bus.per_dout = {14'h0000, rxie, txie};
        default: bus.per_dout = 16'h0000;
      endcase
    end
  end

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_empty ? 16'h0000 : tx_mem[tx_rd_ptr];
  assign bus.rx_ready = !rx_full;
  assign bus.irq      = (txie && tx_empty) || (rxie && !rx_empty);

  // Pointers, counts, control and sticky flags
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      txie      <= 1'b0;
      rxie      <= 1'b0;
      txovf     <= 1'b0;
      rxunf     <= 1'b0;
    end else begin
      if (tx_flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_cnt    <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= AW'(tx_wr_ptr + 1'b1);
        if (tx_pop)  tx_rd_ptr <= AW'(tx_rd_ptr + 1'b1);
        tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end
      if (rx_flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_cnt    <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= AW'(rx_wr_ptr + 1'b1);
        if (rx_pop)  rx_rd_ptr <= AW'(rx_rd_ptr + 1'b1);
        rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      end
      if (ctrl_wr && bus.per_we[0]) begin
        txie <= bus.per_din[0];
        rxie <= bus.per_din[1];
      end
      txovf <= (txovf && !ovf_clr) || ovf_set;
      rxunf <= (rxunf && !unf_clr) || unf_set;
    end
  end

  // FIFO storage is deliberately left unreset
  always_ff @(posedge mclk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_word;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end
endmodule
